// File: rtl/spi_pkg.sv
// Shared opcode and FSM-state encodings for the SPI-attached RAM controller.
package spi_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WR   = 2'b01,
    ST_RD   = 2'b10,
    ST_TX   = 2'b11
  } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM: one write or one registered read per cycle.
// Contents are intentionally left out of reset so data survives rst_n.
module spi_ram_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Write takes priority; a read registers the addressed word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder between an SPI slave and a small byte RAM.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | no address armed; data commands are rejected
//   ST_WR   | write address armed; 01 writes and increments
//   ST_RD   | read address armed; 11 starts a read
//   ST_TX   | read data presented this cycle (tx_valid=1)
module spi_ram_ctrl
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             err
);

  localparam logic [8:0]           DEPTH9 = 9'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST   = ADDR_SIZE'(MEM_DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  err_q, err_d;
  logic [7:0]            tx_hold_q;

  logic                  mem_we, mem_re;
  logic [ADDR_SIZE-1:0]  mem_addr;
  logic [7:0]            mem_rdata;

  logic [1:0]            op;
  logic [7:0]            payload;
  logic                  in_range;

  assign op       = rx_data[9:8];
  assign payload  = rx_data[7:0];
  assign in_range = ({1'b0, payload} < DEPTH9);

  function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  // Next-state, address updates, RAM access and pulse generation.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = wr_addr_q;

    // TX lasts one cycle; a rejected command there still falls back to RD.
    if (state_q == ST_TX) state_d = ST_RD;

    if (rx_valid) begin
      case (op)
        OP_WR_ADDR: begin
          if (in_range) begin
            wr_addr_d = payload[ADDR_SIZE-1:0];
            state_d   = ST_WR;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        OP_RD_ADDR: begin
          if (in_range) begin
            rd_addr_d = payload[ADDR_SIZE-1:0];
            state_d   = ST_RD;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        OP_WR_DATA: begin
          if (state_q == ST_WR) begin
            mem_we    = 1'b1;
            wr_addr_d = addr_inc(wr_addr_q);
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          if (state_q == ST_RD || state_q == ST_TX) begin
            mem_re     = 1'b1;
            mem_addr   = rd_addr_q;
            rd_addr_d  = addr_inc(rd_addr_q);
            tx_valid_d = 1'b1;
            state_d    = ST_TX;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end
  end

  // State and output registers; memory is not touched by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      tx_hold_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      if (tx_valid_q) tx_hold_q <= mem_rdata;
    end
  end

  spi_ram_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_SIZE)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (payload),
    .rdata_o (mem_rdata)
  );

  // RAM output is live only in the TX cycle; otherwise show the held byte
  // so tx_data is stable between reads and reads back 0 after reset.
  assign tx_data  = tx_valid_q ? mem_rdata : tx_hold_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: a 256-deep instance and a 200-deep one.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] rx_data0 = '0, rx_data1 = '0;
  logic       rx_valid0 = 1'b0, rx_valid1 = 1'b0;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_valid0, tx_valid1, err0, err1;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .err(err0)
  );

  spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut200 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .err(err1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One command per cycle: drive at negedge, check the pulses 1ns after the edge.
  task automatic cmd(input bit sel, input logic [1:0] op, input logic [7:0] pl,
                     input bit exp_err, input bit exp_rd, input logic [7:0] exp_d,
                     input string tag);
    logic       v, e;
    logic [7:0] d;
    @(negedge clk);
    if (sel) begin rx_data1 = {op, pl}; rx_valid1 = 1'b1; end
    else     begin rx_data0 = {op, pl}; rx_valid0 = 1'b1; end
    if (exp_rd) sb.push_back(exp_d);
    @(posedge clk);
    #1;
    rx_valid0 = 1'b0;
    rx_valid1 = 1'b0;
    v = sel ? tx_valid1 : tx_valid0;
    e = sel ? err1 : err0;
    d = sel ? tx_data1 : tx_data0;
    chk({tag, ".err"}, {7'b0, e}, {7'b0, exp_err});
    chk({tag, ".tx_valid"}, {7'b0, v}, {7'b0, exp_rd});
    if (v === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s.sb unexpected tx_valid observed=%h expected=none", tag, d);
      end else begin
        chk({tag, ".tx_data"}, d, sb.pop_front());
      end
    end else if (exp_rd) begin
      void'(sb.pop_front());
    end
  endtask

  // Quiet cycle with garbage on rx_data: nothing may pulse, tx_data holds.
  task automatic idle(input string tag, input logic [7:0] hold);
    @(negedge clk);
    rx_data0  = 10'($urandom);
    rx_valid0 = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".tx_valid"}, {7'b0, tx_valid0}, 8'h00);
    chk({tag, ".err"}, {7'b0, err0}, 8'h00);
    chk({tag, ".tx_data"}, tx_data0, hold);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst.tx_data", tx_data0, 8'h00);
    chk("rst.tx_valid", {7'b0, tx_valid0}, 8'h00);
    chk("rst.err", {7'b0, err0}, 8'h00);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Seed mem[0], then reset with a 10 command held high during reset.
    cmd(0, 2'b00, 8'h00, 0, 0, 8'h00, "seed.wa");
    cmd(0, 2'b01, 8'h5A, 0, 0, 8'h00, "seed.wd");
    @(negedge clk);
    #2 rst_n = 1'b0;
    rx_data0  = {2'b10, 8'h00};
    rx_valid0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("inrst.tx_valid", {7'b0, tx_valid0}, 8'h00);
    @(posedge clk);
    #3 rx_valid0 = 1'b0;
    rst_n = 1'b1;

    // Commands after reset: 11 and 01 rejected, mem[0] still 5A.
    cmd(0, 2'b11, 8'h00, 1, 0, 8'h00, "post_rst.rd");
    cmd(0, 2'b01, 8'h33, 1, 0, 8'h00, "post_rst.wd");
    idle("post_rst.idle", 8'h00);
    cmd(0, 2'b10, 8'h00, 0, 0, 8'h00, "m0.ra");
    cmd(0, 2'b11, 8'h00, 0, 1, 8'h5A, "m0.rd");

    // Basic write then read back.
    cmd(0, 2'b00, 8'h10, 0, 0, 8'h00, "basic.wa");
    cmd(0, 2'b01, 8'hA5, 0, 0, 8'h00, "basic.wd");
    cmd(0, 2'b10, 8'h10, 0, 0, 8'h00, "basic.ra");
    cmd(0, 2'b11, 8'h00, 0, 1, 8'hA5, "basic.rd");
    idle("basic.hold", 8'hA5);

    // Write and read address wrap at 255 -> 0.
    cmd(0, 2'b00, 8'hFF, 0, 0, 8'h00, "wrap.wa");
    cmd(0, 2'b01, 8'h11, 0, 0, 8'h00, "wrap.wd0");
    cmd(0, 2'b01, 8'h22, 0, 0, 8'h00, "wrap.wd1");
    cmd(0, 2'b10, 8'hFF, 0, 0, 8'h00, "wrap.ra");
    cmd(0, 2'b11, 8'h00, 0, 1, 8'h11, "wrap.rd255");
    cmd(0, 2'b11, 8'h00, 0, 1, 8'h22, "wrap.rd0");

    // Burst of four back-to-back reads.
    cmd(0, 2'b00, 8'h05, 0, 0, 8'h00, "burst.wa");
    cmd(0, 2'b01, 8'h50, 0, 0, 8'h00, "burst.wd5");
    cmd(0, 2'b01, 8'h61, 0, 0, 8'h00, "burst.wd6");
    cmd(0, 2'b01, 8'h72, 0, 0, 8'h00, "burst.wd7");
    cmd(0, 2'b01, 8'h83, 0, 0, 8'h00, "burst.wd8");
    cmd(0, 2'b10, 8'h05, 0, 0, 8'h00, "burst.ra");
    cmd(0, 2'b11, 8'h00, 0, 1, 8'h50, "burst.rd5");
    cmd(0, 2'b11, 8'h00, 0, 1, 8'h61, "burst.rd6");
    cmd(0, 2'b11, 8'h00, 0, 1, 8'h72, "burst.rd7");
    cmd(0, 2'b11, 8'h00, 0, 1, 8'h83, "burst.rd8");
    idle("burst.hold", 8'h83);

    // 11 while in WR is rejected and leaves WR armed.
    cmd(0, 2'b00, 8'h30, 0, 0, 8'h00, "wrrd.wa");
    cmd(0, 2'b11, 8'h00, 1, 0, 8'h00, "wrrd.rd_in_wr");
    cmd(0, 2'b01, 8'h44, 0, 0, 8'h00, "wrrd.wd");
    cmd(0, 2'b10, 8'h30, 0, 0, 8'h00, "wrrd.ra");
    cmd(0, 2'b11, 8'h00, 0, 1, 8'h44, "wrrd.rd");
    cmd(0, 2'b01, 8'h77, 1, 0, 8'h00, "wrrd.wd_in_rd");

    // Reset asserted in the TX cycle.
    cmd(0, 2'b10, 8'h05, 0, 0, 8'h00, "txrst.ra");
    cmd(0, 2'b11, 8'h00, 0, 1, 8'h50, "txrst.rd");
    #1 rst_n = 1'b0;
    #1;
    chk("txrst.tx_valid", {7'b0, tx_valid0}, 8'h00);
    chk("txrst.tx_data", tx_data0, 8'h00);
    chk("txrst.err", {7'b0, err0}, 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cmd(0, 2'b11, 8'h00, 1, 0, 8'h00, "txrst.rd_after");

    // 200-deep instance: out-of-range loads and wrap at 199.
    cmd(1, 2'b00, 8'hC8, 1, 0, 8'h00, "d200.wa_oor");
    cmd(1, 2'b01, 8'h12, 1, 0, 8'h00, "d200.wd_idle");
    cmd(1, 2'b10, 8'hC8, 1, 0, 8'h00, "d200.ra_oor");
    cmd(1, 2'b11, 8'h00, 1, 0, 8'h00, "d200.rd_idle");
    cmd(1, 2'b00, 8'hC7, 0, 0, 8'h00, "d200.wa");
    cmd(1, 2'b01, 8'h09, 0, 0, 8'h00, "d200.wd199");
    cmd(1, 2'b01, 8'h0A, 0, 0, 8'h00, "d200.wd0");
    cmd(1, 2'b10, 8'hC7, 0, 0, 8'h00, "d200.ra");
    cmd(1, 2'b11, 8'h00, 0, 1, 8'h09, "d200.rd199");
    cmd(1, 2'b11, 8'h00, 0, 1, 8'h0A, "d200.rd0");

    chk("sb.leftover", 8'(sb.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 8-bit words; legal range 2..256.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, address width; MEM_DEPTH <= 2**ADDR_SIZE.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data  input  10  command word from the SPI slave: [9:8] opcode, [7:0] payload.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port tx_data  output  8  read data returned to the SPI slave.
REQ-008 SHALL have port tx_valid  output  1  one-cycle strobe qualifying tx_data.
REQ-009 SHALL have port err  output  1  one-cycle pulse flagging a rejected command.

Function
REQ-010 SHALL treat every clock edge with rx_valid=1 as exactly one command; rx_data is ignored while rx_valid=0.
REQ-011 SHALL implement FSM states IDLE (no address armed), WR (write address armed), RD (read address armed) and TX (read data output).
REQ-012 SHALL, on opcode 00 in any state, load wr_addr<=payload[ADDR_SIZE-1:0] and go to WR.
REQ-013 SHALL, on opcode 10 in any state, load rd_addr<=payload[ADDR_SIZE-1:0] and go to RD.
REQ-014 SHALL, on opcode 01 in WR, write mem[wr_addr]<=payload, increment wr_addr and stay in WR.
REQ-015 SHALL, on opcode 11 in RD or TX, go to TX; in that next cycle drive tx_data=mem[rd_addr] and tx_valid=1, then increment rd_addr.
REQ-016 SHALL return from TX to RD after one cycle unless a new opcode 11 is accepted in that cycle; back-to-back reads give tx_valid on consecutive cycles.
REQ-017 SHALL, on opcode 01 outside WR or opcode 11 in IDLE/WR, pulse err next cycle, leave state, addresses and memory unchanged, and give no tx_valid.
REQ-018 SHALL, on an 00/10 load with payload >= MEM_DEPTH, pulse err and go to IDLE without arming an address.
REQ-019 SHALL wrap auto-incremented addresses from MEM_DEPTH-1 to 0, with no err.
REQ-020 SHALL hold tx_data at its last read value while tx_valid=0.
REQ-021 SHALL keep tx_valid and err at zero except in the single pulse cycles defined above.
REQ-022 SHALL give a read of an address written by a previous command the new data (no stale read).

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-TX, force state IDLE, tx_data=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0 immediately.
REQ-024 SHALL NOT clear memory contents on reset.
REQ-025 SHALL ignore rx_valid while rst_n=0 and accept the first command on the first rising edge after rst_n deasserts.

Structure
REQ-026 SHALL take opcode constants (OP_WR_ADDR=00, OP_WR_DATA=01, OP_RD_ADDR=10, OP_RD_DATA=11) and the FSM state encoding from shared package spi_pkg.
REQ-027 SHALL instantiate the storage as sub-module spi_ram_mem: single-port synchronous RAM, MEM_DEPTH x 8, one access per cycle, no reset.

Verification
REQ-028 Bench SHALL cover: 00/0x10, 01/0xA5, 10/0x10, 11/xx -> tx_data=0xA5 with tx_valid one cycle after the 11 strobe.
REQ-029 Bench SHALL cover: 01/0x33 directly after reset -> err pulse, mem[0] unchanged, no tx_valid.
REQ-030 Bench SHALL cover: 00/0xFF, then 01/0x11 and 01/0x22 -> mem[255]=0x11, mem[0]=0x22 (wrap, no err).
REQ-031 Bench SHALL cover: 10/0x05 then four consecutive 11 strobes -> tx_valid high four consecutive cycles with mem[5..8].
REQ-032 Bench SHALL cover: rst_n low during TX -> tx_valid=0, tx_data=0 immediately; a following 11 gives err.
REQ-033 Bench SHALL cover: MEM_DEPTH=200 with 00/0xC8 -> err, state IDLE, and a following 01 gives err.
